// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle MIPS-style core: ALU-control decode, 32-bit ALU with flags,
// PC+4 and branch-target adders, plus neg/ovf flags registered for next-cycle branch-and-link checks.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [3:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] ext_imm,
  output logic [2:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic        neg,
  output logic        ovf,
  output logic        neg_q,
  output logic        ovf_q,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] s);
    return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] d);
    return (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
  endfunction

  logic [2:0]               w_ctl;
  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_b;
  logic signed [DATA_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_diff;
  logic                     w_lt;
  logic [DATA_W-1:0]        w_res;
  logic                     w_ovf;
  logic                     r_neg_q;
  logic                     r_ovf_q;

  // Priority decode: earlier funct patterns shadow later ones (e.g. 0111 is NOR, not OR).
  always_comb begin
    w_ctl = OP_ADD;
    if (aluop1) begin
      if (funct == 4'b0111)                  w_ctl = OP_NOR;
      else if (funct[2] && funct[0])         w_ctl = OP_OR;
      else if (funct[2] && !funct[0])        w_ctl = OP_AND;
      else if (funct[3] && funct[1])         w_ctl = OP_SLT;
      else if (!funct[3] && funct[1] && !funct[0]) w_ctl = OP_SUB;
      else                                   w_ctl = OP_ADD;
    end else if (aluop0) begin
      w_ctl = OP_SUB;
    end
  end

  assign w_a    = a;
  assign w_b    = b;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  assign w_lt   = (w_a < w_b);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (w_ctl)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = add_ovf(w_a, w_b, w_sum);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = sub_ovf(w_a, w_b, w_diff);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_NOR: w_res = ~(a | b);
      OP_SLT: w_res = {{(DATA_W-1){1'b0}}, w_lt};
      default: w_res = '0;
    endcase
  end

  assign alu_ctl       = w_ctl;
  assign result        = w_res;
  assign zero          = (w_res == '0);
  assign neg           = w_res[DATA_W-1];
  assign ovf           = w_ovf;
  assign pc_plus4      = pc + 32'h4;
  assign branch_target = pc_plus4 + {ext_imm[29:0], 2'b00};

  // Stage boundary: flags held one cycle for the following instruction's link/branch check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_ovf_q <= 1'b0;
    end else begin
      r_neg_q <= neg;
      r_ovf_q <= w_ovf;
    end
  end

  assign neg_q = r_neg_q;
  assign ovf_q = r_ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for decode/ALU/flags, adder cases,
// and hand sequences for the registered flags and asynchronous reset.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        aluop1;
  logic        aluop0;
  logic [3:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] ext_imm;
  logic [2:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic        ovf;
  logic        neg_q;
  logic        ovf_q;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  int checks;
  int errors;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .aluop1(aluop1), .aluop0(aluop0), .funct(funct),
    .a(a), .b(b), .pc(pc), .ext_imm(ext_imm), .alu_ctl(alu_ctl), .result(result),
    .zero(zero), .neg(neg), .ovf(ovf), .neg_q(neg_q), .ovf_q(ovf_q),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op1;
    logic        op0;
    logic [3:0]  fn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [2:0]  e_ctl;
    logic [31:0] e_res;
    logic        e_zero;
    logic        e_neg;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] vpc;
    logic [31:0] vimm;
    logic [31:0] e_p4;
    logic [31:0] e_bt;
  } avec_t;

  vec_t  vecs[14];
  avec_t avecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic set_alu(input logic o1, input logic o0, input logic [3:0] f,
                         input logic [31:0] va, input logic [31:0] vb);
    aluop1 = o1;
    aluop0 = o0;
    funct  = f;
    a      = va;
    b      = vb;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 32'h00000001, 32'h00000002, 3'b010, 32'h00000003, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'b0010, 32'h00000005, 32'h00000007, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'b0100, 32'hF0F0F0F0, 32'h0F0F00FF, 3'b000, 32'h000000F0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'b0101, 32'hF0F0F0F0, 32'h0F0F00FF, 3'b001, 32'hFFFFF0FF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'b0111, 32'hF0F0F0F0, 32'h0F0F00FF, 3'b100, 32'h00000F00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'b1010, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 4'b0000, 32'h12345678, 32'h12345678, 3'b110, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'b0000, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 4'b1010, 32'h00000001, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'b1010, 32'h80000000, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'b0111, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'b1000, 32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 4'b1111, 32'h00000000, 32'h00000000, 3'b001, 32'h00000000, 1'b1, 1'b0, 1'b0};

    avecs[0] = '{32'h00000008, 32'hFFFFFFFE, 32'h0000000C, 32'h00000004};
    avecs[1] = '{32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000};
    avecs[2] = '{32'h00001000, 32'h00000010, 32'h00001004, 32'h00001044};

    rst_n   = 1'b0;
    pc      = 32'h0;
    ext_imm = 32'h0;
    set_alu(1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001);

    // Reset holds registered flags low across edges even with neg/ovf asserted.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_neg_q", {31'b0, neg_q}, 32'h0);
    check("reset_ovf_q", {31'b0, ovf_q}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      set_alu(vecs[i].op1, vecs[i].op0, vecs[i].fn, vecs[i].va, vecs[i].vb);
      #1;
      check($sformatf("v%0d_ctl", i),    {29'b0, alu_ctl}, {29'b0, vecs[i].e_ctl});
      check($sformatf("v%0d_result", i), result,           vecs[i].e_res);
      check($sformatf("v%0d_zero", i),   {31'b0, zero},    {31'b0, vecs[i].e_zero});
      check($sformatf("v%0d_neg", i),    {31'b0, neg},     {31'b0, vecs[i].e_neg});
      check($sformatf("v%0d_ovf", i),    {31'b0, ovf},     {31'b0, vecs[i].e_ovf});
    end

    for (int i = 0; i < 3; i++) begin
      pc      = avecs[i].vpc;
      ext_imm = avecs[i].vimm;
      #1;
      check($sformatf("a%0d_pc_plus4", i), pc_plus4,      avecs[i].e_p4);
      check($sformatf("a%0d_target", i),   branch_target, avecs[i].e_bt);
    end

    // Release reset away from the edge, with ADD-overflow inputs; capture on next edge.
    @(negedge clk);
    set_alu(1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001);
    rst_n = 1'b1;
    #1;
    check("pre_edge_neg_q", {31'b0, neg_q}, 32'h0);
    @(posedge clk); #1;
    check("cap_neg_q", {31'b0, neg_q}, 32'h1);
    check("cap_ovf_q", {31'b0, ovf_q}, 32'h1);

    // Flags cleared combinationally; registered copies keep previous instruction until the edge.
    set_alu(1'b0, 1'b0, 4'b0000, 32'h00000001, 32'h00000001);
    #1;
    check("hold_neg_q", {31'b0, neg_q}, 32'h1);
    check("hold_ovf_q", {31'b0, ovf_q}, 32'h1);
    @(posedge clk); #1;
    check("next_neg_q", {31'b0, neg_q}, 32'h0);
    check("next_ovf_q", {31'b0, ovf_q}, 32'h0);

    // SUB overflow sets ovf_q only.
    set_alu(1'b0, 1'b1, 4'b0000, 32'h80000000, 32'h00000001);
    @(posedge clk); #1;
    check("sub_neg_q", {31'b0, neg_q}, 32'h0);
    check("sub_ovf_q", {31'b0, ovf_q}, 32'h1);

    // Set both flags, then assert reset mid-cycle: must clear without a clock edge.
    set_alu(1'b0, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    check("set_neg_q", {31'b0, neg_q}, 32'h1);
    check("set_ovf_q", {31'b0, ovf_q}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_neg_q", {31'b0, neg_q}, 32'h0);
    check("async_ovf_q", {31'b0, ovf_q}, 32'h0);
    check("async_result", result, 32'h80000000);
    @(posedge clk); #1;
    check("held_neg_q", {31'b0, neg_q}, 32'h0);
    check("held_ovf_q", {31'b0, ovf_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_neg_q", {31'b0, neg_q}, 32'h0);
    @(posedge clk); #1;
    check("recap_neg_q", {31'b0, neg_q}, 32'h1);
    check("recap_ovf_q", {31'b0, ovf_q}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
